mem_access_unit: RTL and testbench

// - Load/store front end between the CPU datapath and the word-only data RAM.
// - Accepts byte/half/word load/store requests and issues word-aligned RAM accesses.
// - Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
// - Misaligned or out-of-window accesses are faulted and never reach the RAM.

---
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end: byte/half/word requests to a word-only RAM, with RMW for sub-word stores.
// Latency: fault 1, load/word store 2, sub-word store 3 cycles; req_ready only in IDLE.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter logic [31:0] DATA_BASE   = 32'h0000_1000,
  parameter int          DATA_WORDS  = 100,
  parameter logic [31:0] STACK_TOP   = 32'hFFFF_FFFC,
  parameter int          STACK_WORDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_fault,
  output logic [31:0] rsp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DATA_END = DATA_BASE + 32'(4 * DATA_WORDS);
  localparam logic [31:0] STACK_LO = STACK_TOP - 32'(4 * (STACK_WORDS - 1));

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP, S_FAULT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic [31:0] w_waddr;
  logic        w_in_window;
  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_waddr     = {req_addr[31:2], 2'b00};
  assign w_in_window = ((w_waddr >= DATA_BASE) && (w_waddr < DATA_END)) ||
                       ((w_waddr >= STACK_LO) && (w_waddr <= STACK_TOP));
  assign w_fault     = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                       !w_in_window;

  // Little-endian lane select on the word currently presented by the RAM.
  assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = mem_rdata;
    if (r_size == 2'b00) begin
      w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault)                 w_next = S_FAULT;
          else if (!req_write)         w_next = S_RD;
          else if (req_size == 2'b10)  w_next = S_WR;
          else                         w_next = S_RMW_RD;
        end
      end
      S_RD:     w_next = S_RESP;
      S_RMW_RD: w_next = S_WR;
      S_WR:     w_next = S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP) || (r_state == S_FAULT);
    rsp_fault = (r_state == S_FAULT);
    rsp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
  end

  // mem_we is registered from the next state so the RAM sees a clean level at its negedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
      r_lane    <= 2'b00;
      r_wdata   <= 16'h0;
      r_rdata   <= 32'h0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      mem_we <= (w_next == S_WR);
      if (w_accept) begin
        r_size   <= req_size;
        r_signed <= req_signed;
        r_lane   <= req_addr[1:0];
        r_wdata  <= req_wdata[15:0];
        r_rdata  <= 32'h0;
        if (!w_fault) begin
          mem_addr <= w_waddr;
          if (req_write && (req_size == 2'b10)) begin
            mem_wdata <= req_wdata;
          end
        end
      end
      if (r_state == S_RD) begin
        r_rdata <= w_load;
      end
      if (r_state == S_RMW_RD) begin
        mem_wdata <= w_merge;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam logic [31:0] D_BASE = 32'h0000_1000;
  localparam logic [31:0] D_END  = 32'h0000_1190;
  localparam logic [31:0] S_LO   = 32'hFFFF_FFD8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM: combinational read, write committed on the negedge.
  logic [31:0] dram [0:99];
  logic [31:0] sram [0:9];
  logic [31:0] d_off, s_off;
  bit          we_seen;

  assign d_off = mem_addr - D_BASE;
  assign s_off = mem_addr - S_LO;

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr >= D_BASE && mem_addr < D_END) mem_rdata = dram[d_off[8:2]];
    else if (mem_addr >= S_LO)                  mem_rdata = sram[s_off[5:2]];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_seen = 1'b1;
      if (mem_addr >= D_BASE && mem_addr < D_END) dram[d_off[8:2]] = mem_wdata;
      else if (mem_addr >= S_LO)                  sram[s_off[5:2]] = mem_wdata;
    end
  end

  // Reference model: flat byte-addressed memory, unwritten bytes read as zero.
  logic [7:0] mb [logic [31:0]];

  function automatic logic [31:0] rbyte(input logic [31:0] a);
    return mb.exists(a) ? {24'h0, mb[a]} : 32'h0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_fault(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (sz == 2'd3) return 1'b1;
    if ((a % nbytes(sz)) != 0) return 1'b1;
    return !((w >= D_BASE && w < D_END) || w >= S_LO);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (rbyte(a + 32'(i)) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < nbytes(sz); i++) begin
      t = wd >> (8 * i);
      mb[a + 32'(i)] = t[7:0];
    end
  endtask

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction starting from IDLE, sampled #1 after each posedge.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    bit          f;
    logic [31:0] exp_rd;
    int          exp_lat, lat;
    f       = ref_fault(sz, a);
    exp_rd  = (!w && !f) ? ref_load(sz, sg, a) : 32'h0;
    exp_lat = f ? 1 : (!w || sz == 2'd2) ? 2 : 3;
    we_seen = 1'b0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    check("busy_ready", {31'h0, req_ready}, 32'h0);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    last_rd = rsp_rdata;
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_fault", {31'h0, rsp_fault}, {31'h0, f});
    check("rsp_rdata", rsp_rdata, exp_rd);
    if (f) check("fault_no_we", {31'h0, we_seen}, 32'h0);
    if (w && !f) ref_store(sz, a, wd);
    @(posedge clk); #1;
  endtask

  initial begin
    int          pulses;
    logic [31:0] a;
    for (int i = 0; i < 100; i++) dram[i] = 32'h0;
    for (int i = 0; i < 10; i++)  sram[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; last_rd = 32'h0;
    #12;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_fault", {31'h0, rsp_fault}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEADBEEF);
    do_op(1'b0, 2'd2, 1'b1, 32'h1004, 32'h0);
    check("lw_const", last_rd, 32'hDEADBEEF);
    check("ram1", dram[1], 32'hDEADBEEF);
    do_op(1'b1, 2'd2, 1'b0, 32'h1008, 32'h11223344);
    do_op(1'b1, 2'd0, 1'b0, 32'h100A, 32'h000000AA);
    check("ram2_rmw", dram[2], 32'h11AA3344);
    do_op(1'b0, 2'd0, 1'b1, 32'h100A, 32'h0);
    check("lb_const", last_rd, 32'hFFFFFFAA);
    do_op(1'b0, 2'd0, 1'b0, 32'h100A, 32'h0);
    check("lbu_const", last_rd, 32'h000000AA);
    do_op(1'b0, 2'd1, 1'b1, 32'h100A, 32'h0);
    check("lh_const", last_rd, 32'h000011AA);

    do_op(1'b0, 2'd2, 1'b0, 32'h1006, 32'h0);
    do_op(1'b1, 2'd1, 1'b0, 32'h1001, 32'h1234);
    do_op(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0);
    do_op(1'b0, 2'd2, 1'b0, 32'h1190, 32'h0);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000, 32'h0);
    do_op(1'b1, 2'd2, 1'b0, 32'h118C, 32'hA5A5_0F0F);
    do_op(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h5);
    do_op(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0);
    check("stack_const", last_rd, 32'h5);
    do_op(1'b0, 2'd2, 1'b0, 32'hFFFFFFD0, 32'h0);
    do_op(1'b1, 2'd1, 1'b0, 32'hFFFFFFD8, 32'h8001);
    do_op(1'b0, 2'd1, 1'b1, 32'hFFFFFFD8, 32'h0);

    // A request held valid is accepted once per pass through IDLE.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h1004; req_wdata = 32'h0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    req_valid = 1'b0;
    check("held_pulses", 32'(pulses), 32'd3);
    @(posedge clk); #1;

    // Reset while the word write is pending: RAM must keep its old word.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h1004; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wr_we_before_rst", {31'h0, mem_we}, 32'h1);
    rst = 1'b1; #1;
    check("wr_rst_we", {31'h0, mem_we}, 32'h0);
    check("wr_rst_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    check("wr_rst_ram", dram[1], 32'hDEADBEEF);
    do_op(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0);

    // Reset during the read half of a read-modify-write.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h1009; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1; #1;
    check("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    check("rmw_rst_ram", dram[2], 32'h11AA3344);
    do_op(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0);

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = D_BASE + 32'($urandom_range(0, 31));
        6, 7:             a = 32'hFFFFFFE0 + 32'($urandom_range(0, 31));
        8:                a = 32'h1180 + 32'($urandom_range(0, 31));
        default:          a = 32'hFFFFFFD0 + 32'($urandom_range(0, 15));
      endcase
      do_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
